// File: rtl/sobel_filter_if.sv
// rtl/sobel_filter_if.sv - FIFO-side pixel stream bundle for the Sobel filter
`timescale 1ns/1ps
interface sobel_filter_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] in_dout;
    logic              in_empty;
    logic              in_rd_en;
    logic [DWIDTH-1:0] out_din;
    logic              out_full;
    logic              out_wr_en;

    // master: the FIFO environment around the filter; slave: the filter itself
    modport master (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_wr_en
    );

    modport slave (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_wr_en
    );
endinterface

// File: rtl/sobel_filter.sv
// rtl/sobel_filter.sv - streaming 3x3 Sobel magnitude filter between two FWFT FIFOs
`timescale 1ns/1ps
module sobel_filter #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540,
    parameter int DWIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    sobel_filter_if.slave io
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int FW = $clog2(WIDTH + 2);
    localparam int GW = DWIDTH + 3;

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [FW-1:0]     flush_cnt_q;
    logic              out_wr_en_q;
    logic [DWIDTH-1:0] out_din_q;

    logic [DWIDTH-1:0] lb0_q [WIDTH];
    logic [DWIDTH-1:0] lb1_q [WIDTH];
    logic [DWIDTH-1:0] win_q [3][3];
    logic [DWIDTH-1:0] win_d [3][3];

    logic              rd_req;
    logic              consume;
    logic              last_col;
    logic              last_row;
    logic              border;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [GW-1:0]     abs_gx;
    logic [GW-1:0]     abs_gy;
    logic [GW:0]       sum;
    logic [GW:0]       half;
    logic [DWIDTH-1:0] mag;

    function automatic logic signed [GW-1:0] ext(input logic [DWIDTH-1:0] v);
        return $signed({3'b000, v});
    endfunction

    always_comb begin
        rd_req = 1'b0;
        case (state_q)
            S_FILL:  rd_req = !io.in_empty;
            S_RUN:   rd_req = !io.in_empty && !io.out_full;
            default: rd_req = 1'b0;
        endcase
    end

    // Reset gates the pop combinationally so the FIFO is never read while held in reset
    assign consume      = reset && rd_req;
    assign io.in_rd_en  = consume;
    assign io.out_wr_en = out_wr_en_q;
    assign io.out_din   = out_din_q;

    assign last_col = (col_q == CW'(WIDTH - 1));
    assign last_row = (row_q == RW'(HEIGHT - 1));

    // Window after shifting in the column that ends at the pixel being consumed
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_q[col_q];
        win_d[1][2] = lb0_q[col_q];
        win_d[2][2] = io.in_dout;
    end

    always_comb begin
        gx = (ext(win_d[0][2]) + ext(win_d[1][2]) + ext(win_d[1][2]) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + ext(win_d[1][0]) + ext(win_d[1][0]) + ext(win_d[2][0]));
        gy = (ext(win_d[2][0]) + ext(win_d[2][1]) + ext(win_d[2][1]) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + ext(win_d[0][1]) + ext(win_d[0][1]) + ext(win_d[0][2]));
        abs_gx = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        sum    = {1'b0, abs_gx} + {1'b0, abs_gy};
        half   = sum >> 1;
        mag    = (|half[GW:DWIDTH]) ? '1 : half[DWIDTH-1:0];
    end

    // Centre is one column left and one row up: consumed column 0 or 1 puts it on the
    // left/right image edge, consumed row 1 puts it on the top edge.
    assign border = (col_q == '0) || (col_q == CW'(1)) || (row_q == RW'(1));

    always_ff @(posedge clock) begin
        if (consume) begin
            win_q        <= win_d;
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= io.in_dout;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            col_q       <= '0;
            row_q       <= '0;
            flush_cnt_q <= '0;
            out_wr_en_q <= 1'b0;
            out_din_q   <= '0;
        end else begin
            out_wr_en_q <= 1'b0;
            if (consume) begin
                col_q <= last_col ? '0 : col_q + 1'b1;
                if (last_col) begin
                    row_q <= last_row ? '0 : row_q + 1'b1;
                end
            end
            case (state_q)
                S_FILL: begin
                    if (consume && col_q == '0 && row_q == RW'(1)) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (consume) begin
                        out_wr_en_q <= 1'b1;
                        out_din_q   <= border ? '0 : mag;
                        if (last_col && last_row) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Remaining outputs all sit on the right column or bottom row
                    if (!io.out_full) begin
                        out_wr_en_q <= 1'b1;
                        out_din_q   <= '0;
                        if (flush_cnt_q == FW'(WIDTH)) begin
                            flush_cnt_q <= '0;
                            state_q     <= S_FILL;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end
endmodule
